// File: rtl/mul_fu_scheduler_if.sv
// Bundle between the multiply RS slots, the iterative multiply FU and the CDB arbiter.
// Latency: none (wires only).
// Backpressure: carried by fu_ready / fu_yumi on the FU side and cdb_req / cdb_grant on the CDB side.
interface mul_fu_scheduler_if #(
    parameter int NUM_REQ = 4
);
    // Result packet the FU produces and the CDB broadcasts unchanged
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  dest_ROB_entry;
    } CDB_packet_t;

    // Reservation-station side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][31:0]  req_a;
    logic [NUM_REQ-1:0][31:0]  req_b;
    logic [NUM_REQ-1:0][3:0]   req_rob;
    logic [NUM_REQ-1:0]        req_high;
    logic [NUM_REQ-1:0]        req_grant;
    logic                      flush;

    // FU side
    logic                      fu_valid_in;
    logic [31:0]               fu_a;
    logic [31:0]               fu_b;
    logic [3:0]                fu_rob;
    logic [3:0]                fu_aluop;
    logic                      fu_ready;
    logic                      fu_valid_out;
    CDB_packet_t               fu_out;
    logic                      fu_yumi;

    // CDB side
    logic                      cdb_req;
    logic                      cdb_grant;
    CDB_packet_t               cdb_packet;

    // Scheduler view
    modport master (
        input  req_valid, req_a, req_b, req_rob, req_high, flush,
        input  fu_ready, fu_valid_out, fu_out, cdb_grant,
        output req_grant, fu_valid_in, fu_a, fu_b, fu_rob, fu_aluop,
        output fu_yumi, cdb_req, cdb_packet
    );

    // Surrounding pipeline view (RS, FU, CDB arbiter)
    modport slave (
        output req_valid, req_a, req_b, req_rob, req_high, flush,
        output fu_ready, fu_valid_out, fu_out, cdb_grant,
        input  req_grant, fu_valid_in, fu_a, fu_b, fu_rob, fu_aluop,
        input  fu_yumi, cdb_req, cdb_packet
    );
endinterface

// File: rtl/mul_fu_scheduler.sv
// Round-robin shares one iterative multiply FU among NUM_REQ RS slots and hands its result to the CDB.
// Latency: grant/issue is combinational in IDLE; result reaches CDB after FU compute + 1 cycle + CDB wait.
// Backpressure: one op in flight; RESULT holds cdb_req and a stable packet until cdb_grant or flush.
module mul_fu_scheduler #(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    mul_fu_scheduler_if.master  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESULT = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_rr_ptr_nxt;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W:0]   w_scan;
    logic             w_found;
    logic             w_issue;
    logic             w_yumi;
    logic             w_cdb_req;

    // Round-robin pick: first valid slot at or after r_rr_ptr, wrapping at NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && bus.req_valid[w_scan[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[PTR_W-1:0];
            end
        end
    end

    // Next state, pointer advance and handshake strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_issue      = 1'b0;
        w_yumi       = 1'b0;
        w_cdb_req    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fu_ready && w_found && !bus.flush) begin
                    w_issue      = 1'b1;
                    w_state_nxt  = BUSY;
                    w_rr_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                end
            end
            BUSY: begin
                // Flush beats a same-cycle result; DRAIN consumes it without broadcasting
                if (bus.flush) begin
                    w_state_nxt = DRAIN;
                end else if (bus.fu_valid_out) begin
                    w_state_nxt = RESULT;
                end
            end
            RESULT: begin
                w_cdb_req = !bus.flush;
                if (bus.flush || bus.cdb_grant) begin
                    w_yumi      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (bus.fu_valid_out) begin
                    w_yumi      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Grant and FU operand mux; everything is forced low while reset is held
    always_comb begin
        bus.req_grant   = '0;
        bus.fu_valid_in = 1'b0;
        bus.fu_a        = '0;
        bus.fu_b        = '0;
        bus.fu_rob      = '0;
        bus.fu_aluop    = '0;
        if (w_issue && !reset) begin
            bus.req_grant[w_win] = 1'b1;
            bus.fu_valid_in      = 1'b1;
            bus.fu_a             = bus.req_a[w_win];
            bus.fu_b             = bus.req_b[w_win];
            bus.fu_rob           = bus.req_rob[w_win];
            bus.fu_aluop         = {3'b000, bus.req_high[w_win]};
        end
    end

    assign bus.fu_yumi    = w_yumi & ~reset;
    assign bus.cdb_req    = w_cdb_req & ~reset;
    // The FU holds its result until yumi, so the pass-through packet stays stable while waiting
    assign bus.cdb_packet = bus.fu_out;

endmodule

// File: tb/tb_mul_fu_scheduler.sv
// Directed bench for mul_fu_scheduler with a behavioural iterative-multiplier FU.
// Latency: FU model takes FU_LAT cycles per op plus one recovery cycle after yumi.
// Backpressure: cdb_grant and flush are driven per scenario.
module tb_mul_fu_scheduler;
    localparam int NUM_REQ = 4;
    localparam int FU_LAT  = 16;
    localparam int BUDGET  = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_fu_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();
    mul_fu_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int errors = 0;
    int checks = 0;
    int yumi_cnt  = 0;
    int grant_cnt = 0;
    int bcast_cnt = 0;

    // Event counters sampled away from the active edge
    always @(negedge clk) begin
        if (bus.fu_yumi)                  yumi_cnt++;
        if (|bus.req_grant)               grant_cnt++;
        if (bus.cdb_req && bus.cdb_grant) bcast_cnt++;
    end

    // ---------------- behavioural FU ----------------
    logic [1:0]  fu_st = 2'd0;
    int          fu_cnt = 0;
    logic [31:0] fu_res = '0;
    logic [3:0]  fu_dst = '0;

    function automatic logic [31:0] fu_calc(input logic [31:0] a, input logic [31:0] b, input logic hi);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return hi ? p[63:32] : p[31:0];
    endfunction

    assign bus.fu_ready     = (fu_st == 2'd0);
    assign bus.fu_valid_out = (fu_st == 2'd2);
    assign bus.fu_out       = {fu_res, fu_dst};

    // FU model: idle -> compute FU_LAT cycles -> hold result until yumi -> one recovery cycle
    always @(posedge clk) begin
        if (reset) begin
            fu_st  <= 2'd0;
            fu_cnt <= 0;
        end else begin
            case (fu_st)
                2'd0: if (bus.fu_valid_in) begin
                    fu_res <= fu_calc(bus.fu_a, bus.fu_b, bus.fu_aluop[0]);
                    fu_dst <= bus.fu_rob;
                    fu_cnt <= FU_LAT;
                    fu_st  <= 2'd1;
                end
                2'd1: if (fu_cnt <= 1) fu_st <= 2'd2; else fu_cnt <= fu_cnt - 1;
                2'd2: if (bus.fu_yumi) fu_st <= 2'd3;
                default: fu_st <= 2'd0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int n = 0; n < BUDGET && !ok; n++) begin
            @(negedge clk);
            if (|bus.req_grant) begin
                ok = 1'b1;
                for (int s = 0; s < NUM_REQ; s++) if (bus.req_grant[s]) idx = s;
            end
        end
    endtask

    task automatic wait_cdb_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BUDGET && !ok; n++) begin
            @(negedge clk);
            if (bus.cdb_req) ok = 1'b1;
        end
    endtask

    task automatic wait_bcast(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BUDGET && !ok; n++) begin
            @(negedge clk);
            if (bus.cdb_req && bus.cdb_grant) ok = 1'b1;
        end
    endtask

    task automatic wait_yumi(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < BUDGET && !ok; n++) begin
            @(negedge clk);
            if (bus.fu_yumi) ok = 1'b1;
        end
    endtask

    task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] rob, input logic hi);
        bus.req_a[s]    = a;
        bus.req_b[s]    = b;
        bus.req_rob[s]  = rob;
        bus.req_high[s] = hi;
    endtask

    // One complete op on slot s with cdb_grant already high
    task automatic do_op(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rob, input logic hi,
                         output int gidx, output logic [3:0] op,
                         output logic [31:0] res, output logic [3:0] dst, output bit ok);
        bit ok1;
        bit ok2;
        tick();
        set_slot(s, a, b, rob, hi);
        bus.req_valid    = '0;
        bus.req_valid[s] = 1'b1;
        wait_grant(gidx, ok1);
        op = bus.fu_aluop;
        tick();
        bus.req_valid = '0;
        wait_bcast(ok2);
        res = bus.cdb_packet.result;
        dst = bus.cdb_packet.dest_ROB_entry;
        ok  = ok1 && ok2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", bus.req_grant); end
        checks++; if (bus.fu_valid_in !== 1'b0) begin errors++; $display("FAIL reset_fu_valid_in: got %b want 0", bus.fu_valid_in); end
        checks++; if (bus.fu_yumi !== 1'b0) begin errors++; $display("FAIL reset_fu_yumi: got %b want 0", bus.fu_yumi); end
        checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL reset_cdb_req: got %b want 0", bus.cdb_req); end
        checks++; if (bus.fu_a !== 32'd0 || bus.fu_aluop !== 4'd0) begin errors++; $display("FAIL reset_operands: got a=%0h op=%0h want 0", bus.fu_a, bus.fu_aluop); end
        tick();
        reset         = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_rr_fairness();
        int idx;
        bit ok;
        tick();
        for (int s = 0; s < NUM_REQ; s++) set_slot(s, 32'(s + 1), 32'd10, 4'(s), 1'b0);
        bus.cdb_grant = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_grant(idx, ok);
            checks++; if (!ok || idx != (i % 4)) begin errors++; $display("FAIL rr_order[%0d]: got slot %0d want %0d", i, idx, i % 4); end
            if (i == 0) begin
                checks++; if (bus.fu_a !== 32'd1) begin errors++; $display("FAIL rr_first_operand: got %0d want 1", bus.fu_a); end
            end
        end
        tick();
        bus.req_valid = '0;
        wait_yumi(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_last_yumi: timeout want yumi"); end
    endtask

    task automatic test_single();
        int idx;
        bit ok;
        int g0, y0, b0;
        tick();
        g0 = grant_cnt; y0 = yumi_cnt; b0 = bcast_cnt;
        set_slot(2, 32'd5, 32'd7, 4'd9, 1'b0);
        bus.cdb_grant = 1'b1;
        bus.req_valid = 4'b0100;
        wait_grant(idx, ok);
        checks++; if (!ok || bus.req_grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", bus.req_grant); end
        checks++; if (bus.fu_valid_in !== 1'b1 || bus.fu_a !== 32'd5 || bus.fu_b !== 32'd7) begin errors++; $display("FAIL single_issue: got v=%b a=%0d b=%0d want 1/5/7", bus.fu_valid_in, bus.fu_a, bus.fu_b); end
        checks++; if (bus.fu_rob !== 4'd9 || bus.fu_aluop !== 4'd0) begin errors++; $display("FAIL single_tag: got rob=%0d op=%0d want 9/0", bus.fu_rob, bus.fu_aluop); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.req_grant !== 4'b0000 || bus.fu_valid_in !== 1'b0) begin errors++; $display("FAIL single_grant_one_cycle: got %b/%b want 0000/0", bus.req_grant, bus.fu_valid_in); end
        wait_bcast(ok);
        checks++; if (!ok || bus.cdb_packet.result !== 32'd35) begin errors++; $display("FAIL single_result: got %0d want 35", bus.cdb_packet.result); end
        checks++; if (bus.cdb_packet.dest_ROB_entry !== 4'd9 || bus.fu_yumi !== 1'b1) begin errors++; $display("FAIL single_dest_yumi: got rob=%0d yumi=%b want 9/1", bus.cdb_packet.dest_ROB_entry, bus.fu_yumi); end
        repeat (5) tick();
        checks++; if (yumi_cnt - y0 != 1 || grant_cnt - g0 != 1 || bcast_cnt - b0 != 1) begin errors++; $display("FAIL single_counts: got yumi=%0d grant=%0d bcast=%0d want 1/1/1", yumi_cnt - y0, grant_cnt - g0, bcast_cnt - b0); end
    endtask

    task automatic test_mulh();
        int idx;
        logic [3:0] op, dst;
        logic [31:0] res;
        bit ok;
        bus.cdb_grant = 1'b1;
        do_op(1, 32'd65536, 32'd65536, 4'd3, 1'b1, idx, op, res, dst, ok);
        checks++; if (!ok || op !== 4'd1) begin errors++; $display("FAIL mulh_aluop: got %0d want 1", op); end
        checks++; if (res !== 32'd1 || dst !== 4'd3) begin errors++; $display("FAIL mulh_result: got %0h rob=%0d want 1 rob=3", res, dst); end
        do_op(0, 32'hFFFF_FFF6, 32'd3, 4'd4, 1'b0, idx, op, res, dst, ok);
        checks++; if (!ok || res !== 32'hFFFF_FFE2) begin errors++; $display("FAIL mul_neg_result: got %0h want ffffffe2", res); end
    endtask

    task automatic test_backpressure();
        int idx;
        bit ok;
        int g0, y0;
        logic [35:0] pkt;
        tick();
        bus.cdb_grant = 1'b0;
        set_slot(3, 32'd6, 32'd7, 4'd5, 1'b0);
        set_slot(0, 32'd2, 32'd3, 4'd8, 1'b0);
        bus.req_valid = 4'b1000;
        wait_grant(idx, ok);
        checks++; if (!ok || idx != 3) begin errors++; $display("FAIL bp_grant_slot: got %0d want 3", idx); end
        tick();
        bus.req_valid = 4'b0001;
        wait_cdb_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_cdb_req: timeout want cdb_req"); end
        pkt = bus.cdb_packet;
        tick();
        g0 = grant_cnt; y0 = yumi_cnt;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++; if (bus.cdb_req !== 1'b1 || bus.cdb_packet !== pkt) begin errors++; $display("FAIL bp_hold[%0d]: got req=%b pkt=%0h want 1/%0h", n, bus.cdb_req, bus.cdb_packet, pkt); end
            checks++; if (bus.fu_yumi !== 1'b0 || bus.req_grant !== 4'b0000) begin errors++; $display("FAIL bp_quiet[%0d]: got yumi=%b grant=%b want 0/0000", n, bus.fu_yumi, bus.req_grant); end
        end
        tick();
        checks++; if (yumi_cnt != y0 || grant_cnt != g0) begin errors++; $display("FAIL bp_counts: got yumi+%0d grant+%0d want 0/0", yumi_cnt - y0, grant_cnt - g0); end
        bus.cdb_grant = 1'b1;
        @(negedge clk);
        checks++; if (bus.fu_yumi !== 1'b1 || bus.cdb_packet.result !== 32'd42 || bus.cdb_packet.dest_ROB_entry !== 4'd5) begin errors++; $display("FAIL bp_release: got yumi=%b res=%0d rob=%0d want 1/42/5", bus.fu_yumi, bus.cdb_packet.result, bus.cdb_packet.dest_ROB_entry); end
        tick();
        checks++; if (yumi_cnt != y0 + 1) begin errors++; $display("FAIL bp_single_yumi: got %0d want 1", yumi_cnt - y0); end
        wait_grant(idx, ok);
        checks++; if (!ok || idx != 0) begin errors++; $display("FAIL bp_next_grant: got %0d want 0", idx); end
        tick();
        bus.req_valid = '0;
        wait_yumi(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_next_yumi: timeout want yumi"); end
    endtask

    task automatic test_flush_busy();
        int idx;
        bit ok, saw_req;
        int y0, b0;
        logic [3:0] op, dst;
        logic [31:0] res;
        tick();
        bus.cdb_grant = 1'b1;
        set_slot(1, 32'd3, 32'd4, 4'd6, 1'b0);
        bus.req_valid = 4'b0010;
        wait_grant(idx, ok);
        checks++; if (!ok || idx != 1) begin errors++; $display("FAIL flush_grant_slot: got %0d want 1", idx); end
        tick();
        bus.req_valid = '0;
        y0 = yumi_cnt; b0 = bcast_cnt;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        saw_req = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < BUDGET && !ok; n++) begin
            @(negedge clk);
            if (bus.cdb_req) saw_req = 1'b1;
            if (bus.fu_yumi) ok = 1'b1;
        end
        checks++; if (!ok || bus.fu_valid_out !== 1'b1) begin errors++; $display("FAIL flush_drain_yumi: got ok=%b fu_valid_out=%b want 1/1", ok, bus.fu_valid_out); end
        checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL flush_no_cdb_req: got %b want 0", saw_req); end
        tick();
        checks++; if (bcast_cnt != b0 || yumi_cnt != y0 + 1) begin errors++; $display("FAIL flush_counts: got bcast+%0d yumi+%0d want 0/1", bcast_cnt - b0, yumi_cnt - y0); end
        do_op(2, 32'd2, 32'd9, 4'd7, 1'b0, idx, op, res, dst, ok);
        checks++; if (!ok || res !== 32'd18 || dst !== 4'd7) begin errors++; $display("FAIL flush_next_op: got %0d rob=%0d want 18 rob=7", res, dst); end
    endtask

    task automatic test_flush_result();
        int idx;
        bit ok;
        int y0, b0;
        tick();
        bus.cdb_grant = 1'b0;
        set_slot(3, 32'd1, 32'd1, 4'd2, 1'b0);
        bus.req_valid = 4'b1000;
        wait_grant(idx, ok);
        tick();
        bus.req_valid = '0;
        wait_cdb_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fr_cdb_req: timeout want cdb_req"); end
        tick();
        y0 = yumi_cnt; b0 = bcast_cnt;
        bus.flush     = 1'b1;
        bus.cdb_grant = 1'b1;
        @(negedge clk);
        checks++; if (bus.cdb_req !== 1'b0 || bus.fu_yumi !== 1'b1) begin errors++; $display("FAIL fr_flush_wins: got req=%b yumi=%b want 0/1", bus.cdb_req, bus.fu_yumi); end
        tick();
        bus.flush     = 1'b0;
        bus.cdb_grant = 1'b0;
        repeat (3) tick();
        checks++; if (bcast_cnt != b0 || yumi_cnt != y0 + 1) begin errors++; $display("FAIL fr_counts: got bcast+%0d yumi+%0d want 0/1", bcast_cnt - b0, yumi_cnt - y0); end
    endtask

    task automatic test_reset_mid_busy();
        int idx;
        bit ok;
        int y0;
        tick();
        bus.cdb_grant = 1'b1;
        set_slot(2, 32'd2, 32'd2, 4'd1, 1'b0);
        bus.req_valid = 4'b0100;
        wait_grant(idx, ok);
        checks++; if (!ok || idx != 2) begin errors++; $display("FAIL rst_busy_grant: got %0d want 2", idx); end
        tick();
        bus.req_valid = '0;
        repeat (4) tick();
        reset = 1'b1;
        y0 = yumi_cnt;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_grant !== 4'b0000 || bus.fu_valid_in !== 1'b0 || bus.fu_yumi !== 1'b0 || bus.cdb_req !== 1'b0) begin errors++; $display("FAIL rst_busy_outputs: got grant=%b v=%b yumi=%b req=%b want all 0", bus.req_grant, bus.fu_valid_in, bus.fu_yumi, bus.cdb_req); end
        tick();
        for (int s = 0; s < NUM_REQ; s++) set_slot(s, 32'd1, 32'd1, 4'(s), 1'b0);
        bus.req_valid = 4'b1111;
        wait_grant(idx, ok);
        checks++; if (!ok || idx != 0) begin errors++; $display("FAIL rst_busy_rr_ptr: got slot %0d want 0", idx); end
        tick();
        bus.req_valid = '0;
        wait_yumi(ok);
        tick();
        checks++; if (!ok || yumi_cnt != y0 + 1) begin errors++; $display("FAIL rst_busy_yumi: got yumi+%0d want 1", yumi_cnt - y0); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_rob   = '0;
        bus.req_high  = '0;
        bus.flush     = 1'b0;
        bus.cdb_grant = 1'b0;
        test_reset();
        test_rr_fairness();
        test_single();
        test_mulh();
        test_backpressure();
        test_flush_busy();
        test_flush_result();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
